// File: rtl/multi_player_ctrl_pkg.sv
// Shared types and constants for the multi-player hop/score engine.
//   hop_state_e : per-player FSM state
//   dir_e       : latched hop direction
//   KEYMAP      : HID keycode per [player][up, down, left, right]
//   SCORE_MAX   : score saturation value
package mpc_pkg;

   typedef enum logic [1:0] {
      IDLE,
      HOP,
      COOLDOWN
   } hop_state_e;

   typedef enum logic [1:0] {
      DIR_UP,
      DIR_DOWN,
      DIR_LEFT,
      DIR_RIGHT
   } dir_e;

   // Row = player, column = dir_e order (up, down, left, right).
   localparam logic [7:0] KEYMAP [4][4] = '{
      '{8'h1A, 8'h16, 8'h04, 8'h07},   // W S A D
      '{8'h52, 8'h51, 8'h50, 8'h4F},   // arrows
      '{8'h0C, 8'h0E, 8'h0D, 8'h0F},   // I K J L
      '{8'h60, 8'h5D, 8'h5C, 8'h5E}    // keypad 8 5 4 6
   };

   localparam logic [6:0] SCORE_MAX = 7'd99;

endpackage

// File: rtl/multi_player_ctrl_if.sv
// Bus bundle between the SoC/VGA side and multi_player_ctrl.
//   frame_vs       : VGA vsync, active low, asynchronous
//   keycodes       : packed HID keycodes, slot k at [8k+7:8k]
//   frame_tick     : one-clock pulse per frame
//   player_x/y     : 10-bit positions, player i at [10i+9:10i]
//   player_score   : 7-bit scores, player i at [7i+6:7i]
//   player_hopping : 1 while player i is mid-hop
interface multi_player_ctrl_if #(
   parameter int N_PLAYERS = 2,
   parameter int N_KEYS    = 4
);
   logic                      frame_vs;
   logic [8*N_KEYS-1:0]       keycodes;
   logic                      frame_tick;
   logic [10*N_PLAYERS-1:0]   player_x;
   logic [10*N_PLAYERS-1:0]   player_y;
   logic [7*N_PLAYERS-1:0]    player_score;
   logic [N_PLAYERS-1:0]      player_hopping;

   modport master (
      output frame_vs, keycodes,
      input  frame_tick, player_x, player_y, player_score, player_hopping
   );

   modport slave (
      input  frame_vs, keycodes,
      output frame_tick, player_x, player_y, player_score, player_hopping
   );
endinterface

// File: rtl/multi_player_ctrl_player_hop_fsm.sv
// One player's hop engine: press detection, IDLE/HOP/COOLDOWN FSM,
// position with wall clamping, and saturating goal score.
//   i_clk, i_rst : clock, synchronous active-high reset
//   i_tick       : one-clock frame pulse; all state advances on it
//   i_dir_held   : {up, down, left, right} keys currently held
//   o_x, o_y     : position
//   o_score      : score 0..99
//   o_hopping    : 1 while in HOP
module player_hop_fsm
   import mpc_pkg::*;
#(
   parameter int PLAYER_IDX  = 0,
   parameter int STEP        = 4,
   parameter int HOP_FRAMES  = 4,
   parameter int COOL_FRAMES = 2,
   parameter int X_MIN       = 0,
   parameter int X_MAX       = 624,
   parameter int Y_MIN       = 0,
   parameter int Y_MAX       = 464,
   parameter int Y_GOAL      = 16,
   parameter int X_START     = 160,
   parameter int X_SPACING   = 96,
   parameter int Y_START     = 448
) (
   input  logic       i_clk,
   input  logic       i_rst,
   input  logic       i_tick,
   input  logic [3:0] i_dir_held,
   output logic [9:0] o_x,
   output logic [9:0] o_y,
   output logic [6:0] o_score,
   output logic       o_hopping
);

   localparam logic [9:0]         X_HOME    = 10'(X_START + PLAYER_IDX * X_SPACING);
   localparam logic [9:0]         Y_HOME    = 10'(Y_START);
   localparam logic [7:0]         HOP_LOAD  = 8'(HOP_FRAMES);
   localparam logic [7:0]         COOL_LOAD = 8'(COOL_FRAMES);
   localparam logic signed [10:0] W_STEP    = 11'(STEP);

   function automatic logic [9:0] clamp_pos(input logic signed [10:0] v,
                                            input int lo, input int hi);
      if (int'(v) < lo)      return 10'(lo);
      else if (int'(v) > hi) return 10'(hi);
      else                   return v[9:0];
   endfunction

   hop_state_e r_state, w_state_nxt;
   dir_e       r_dir, w_dir_nxt;
   logic [7:0] r_cnt, w_cnt_nxt;
   logic [9:0] r_x, r_y, w_x_nxt, w_y_nxt, w_mx, w_my;
   logic [6:0] r_score, w_score_nxt;
   logic [3:0] r_prev;
   logic [3:0] w_new;
   logic signed [10:0] w_sx, w_sy;

   assign w_new = i_dir_held & ~r_prev;
   assign w_sx  = $signed({1'b0, r_x});
   assign w_sy  = $signed({1'b0, r_y});

   // Candidate position one step along the latched direction, clamped.
   always_comb begin
      w_mx = r_x;
      w_my = r_y;
      case (r_dir)
         DIR_UP:    w_my = clamp_pos(w_sy - W_STEP, Y_MIN, Y_MAX);
         DIR_DOWN:  w_my = clamp_pos(w_sy + W_STEP, Y_MIN, Y_MAX);
         DIR_LEFT:  w_mx = clamp_pos(w_sx - W_STEP, X_MIN, X_MAX);
         default:   w_mx = clamp_pos(w_sx + W_STEP, X_MIN, X_MAX);
      endcase
   end

   always_comb begin
      w_state_nxt = r_state;
      w_dir_nxt   = r_dir;
      w_cnt_nxt   = r_cnt;
      w_x_nxt     = r_x;
      w_y_nxt     = r_y;
      w_score_nxt = r_score;
      if (i_tick) begin
         case (r_state)
            IDLE: begin
               if (w_new != 4'b0000) begin
                  if (w_new[3])      w_dir_nxt = DIR_UP;
                  else if (w_new[2]) w_dir_nxt = DIR_DOWN;
                  else if (w_new[1]) w_dir_nxt = DIR_LEFT;
                  else               w_dir_nxt = DIR_RIGHT;
                  w_cnt_nxt   = HOP_LOAD;
                  w_state_nxt = HOP;
               end
            end
            HOP: begin
               w_x_nxt   = w_mx;
               w_y_nxt   = w_my;
               w_cnt_nxt = r_cnt - 8'd1;
               if (r_cnt == 8'd1) begin
                  // Goal test uses the position just reached on this step.
                  if (int'(w_my) <= Y_GOAL) begin
                     if (r_score < SCORE_MAX) w_score_nxt = r_score + 7'd1;
                     w_x_nxt = X_HOME;
                     w_y_nxt = Y_HOME;
                  end
                  w_cnt_nxt   = COOL_LOAD;
                  w_state_nxt = (COOL_FRAMES == 0) ? IDLE : COOLDOWN;
               end
            end
            COOLDOWN: begin
               w_cnt_nxt = r_cnt - 8'd1;
               if (r_cnt == 8'd1) w_state_nxt = IDLE;
            end
            default: w_state_nxt = IDLE;
         endcase
      end
   end

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         r_state <= IDLE;
         r_dir   <= DIR_UP;
         r_cnt   <= 8'd0;
         r_x     <= X_HOME;
         r_y     <= Y_HOME;
         r_score <= 7'd0;
         // All keys treated as already held, so a key held through reset
         // must be released and pressed again before it hops.
         r_prev  <= 4'b1111;
      end else begin
         r_state <= w_state_nxt;
         r_dir   <= w_dir_nxt;
         r_cnt   <= w_cnt_nxt;
         r_x     <= w_x_nxt;
         r_y     <= w_y_nxt;
         r_score <= w_score_nxt;
         if (i_tick) r_prev <= i_dir_held;
      end
   end

   assign o_x       = r_x;
   assign o_y       = r_y;
   assign o_score   = r_score;
   assign o_hopping = (r_state == HOP);

endmodule

// File: rtl/multi_player_ctrl.sv
// N-player movement/scoring engine: vsync synchroniser and falling-edge
// frame tick, HID keycode decode per player, one player_hop_fsm per player.
//   Clk   : system clock
//   Reset : synchronous active-high reset
//   bus   : slave side of multi_player_ctrl_if (vsync/keycodes in,
//           frame_tick/positions/scores/hopping out)
module multi_player_ctrl
   import mpc_pkg::*;
#(
   parameter int N_PLAYERS   = 2,
   parameter int N_KEYS      = 4,
   parameter int STEP        = 4,
   parameter int HOP_FRAMES  = 4,
   parameter int COOL_FRAMES = 2,
   parameter int X_MIN       = 0,
   parameter int X_MAX       = 624,
   parameter int Y_MIN       = 0,
   parameter int Y_MAX       = 464,
   parameter int Y_GOAL      = 16,
   parameter int X_START     = 160,
   parameter int X_SPACING   = 96,
   parameter int Y_START     = 448
) (
   input  logic             Clk,
   input  logic             Reset,
   multi_player_ctrl_if.slave bus
);

   logic r_vs_s1, r_vs_s2, r_vs_s3, r_frame_tick;
   logic w_fall;

   logic [N_PLAYERS-1:0][3:0] w_dir_held;
   logic [N_PLAYERS-1:0][9:0] w_x, w_y;
   logic [N_PLAYERS-1:0][6:0] w_score;
   logic [N_PLAYERS-1:0]      w_hopping;

   // Two-flop synchroniser plus one delay flop for the edge detect.
   assign w_fall = r_vs_s3 & ~r_vs_s2;

   always_ff @(posedge Clk) begin
      if (Reset) begin
         r_vs_s1      <= 1'b1;
         r_vs_s2      <= 1'b1;
         r_vs_s3      <= 1'b1;
         r_frame_tick <= 1'b0;
      end else begin
         r_vs_s1      <= bus.frame_vs;
         r_vs_s2      <= r_vs_s1;
         r_vs_s3      <= r_vs_s2;
         r_frame_tick <= w_fall;
      end
   end

   // Bit order {up, down, left, right}; any slot matching sets the bit.
   always_comb begin
      w_dir_held = '0;
      for (int i = 0; i < N_PLAYERS; i++)
         for (int d = 0; d < 4; d++)
            for (int k = 0; k < N_KEYS; k++)
               if (bus.keycodes[8*k +: 8] == KEYMAP[i][d])
                  w_dir_held[i][3-d] = 1'b1;
   end

   for (genvar g = 0; g < N_PLAYERS; g++) begin : g_player
      player_hop_fsm #(
         .PLAYER_IDX (g),
         .STEP       (STEP),
         .HOP_FRAMES (HOP_FRAMES),
         .COOL_FRAMES(COOL_FRAMES),
         .X_MIN      (X_MIN),
         .X_MAX      (X_MAX),
         .Y_MIN      (Y_MIN),
         .Y_MAX      (Y_MAX),
         .Y_GOAL     (Y_GOAL),
         .X_START    (X_START),
         .X_SPACING  (X_SPACING),
         .Y_START    (Y_START)
      ) u_player (
         .i_clk      (Clk),
         .i_rst      (Reset),
         .i_tick     (r_frame_tick),
         .i_dir_held (w_dir_held[g]),
         .o_x        (w_x[g]),
         .o_y        (w_y[g]),
         .o_score    (w_score[g]),
         .o_hopping  (w_hopping[g])
      );
   end

   assign bus.frame_tick     = r_frame_tick;
   assign bus.player_x       = w_x;
   assign bus.player_y       = w_y;
   assign bus.player_score   = w_score;
   assign bus.player_hopping = w_hopping;

endmodule

// File: tb/tb_multi_player_ctrl.sv
// Bench for multi_player_ctrl: a default 2-player instance and a 1-player
// instance with an always-reachable goal and no cooldown, both driven by the
// same vsync/keycodes and compared each frame against a behavioural model.
module tb_multi_player_ctrl;

   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   multi_player_ctrl_if #(.N_PLAYERS(2), .N_KEYS(4)) ifa ();
   multi_player_ctrl_if #(.N_PLAYERS(1), .N_KEYS(4)) ifb ();

   multi_player_ctrl #(.N_PLAYERS(2), .N_KEYS(4)) dut_a (
      .Clk   (clk),
      .Reset (rst),
      .bus   (ifa.slave)
   );

   multi_player_ctrl #(.N_PLAYERS(1), .N_KEYS(4), .Y_GOAL(464), .COOL_FRAMES(0)) dut_b (
      .Clk   (clk),
      .Reset (rst),
      .bus   (ifb.slave)
   );

   int n_chk = 0;
   int n_err = 0;

   // Model players: 0,1 = instance A players, 2 = instance B player 0.
   localparam int NP = 3;
   int m_goal [NP] = '{16, 16, 464};
   int m_cool [NP] = '{2, 2, 0};
   int m_map  [NP] = '{0, 1, 0};
   int m_x0   [NP] = '{160, 256, 160};
   int km [4][4] = '{'{'h1A, 'h16, 'h04, 'h07},
                     '{'h52, 'h51, 'h50, 'h4F},
                     '{'h0C, 'h0E, 'h0D, 'h0F},
                     '{'h60, 'h5D, 'h5C, 'h5E}};

   int mx [NP], my [NP], msc [NP], mhop [NP], mcool [NP], mdir [NP];
   logic [3:0] mprev [NP];

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0d, expected %0d at %0t", tag, got, exp, $time);
      end
   endtask

   task automatic model_reset();
      for (int p = 0; p < NP; p++) begin
         mx[p] = m_x0[p]; my[p] = 448; msc[p] = 0;
         mhop[p] = 0; mcool[p] = 0; mdir[p] = 0; mprev[p] = 4'hF;
      end
   endtask

   task automatic model_tick(input logic [31:0] keys);
      logic [3:0] held, nw;
      logic [7:0] slot;
      for (int p = 0; p < NP; p++) begin
         held = 4'b0;
         for (int d = 0; d < 4; d++)
            for (int k = 0; k < 4; k++) begin
               slot = keys[8*k +: 8];
               if (int'(slot) == km[m_map[p]][d]) held[3-d] = 1'b1;
            end
         nw = held & ~mprev[p];
         mprev[p] = held;
         if (mhop[p] > 0) begin
            case (mdir[p])
               0: my[p] = my[p] - 4;
               1: my[p] = my[p] + 4;
               2: mx[p] = mx[p] - 4;
               default: mx[p] = mx[p] + 4;
            endcase
            if (mx[p] < 0) mx[p] = 0;
            if (mx[p] > 624) mx[p] = 624;
            if (my[p] < 0) my[p] = 0;
            if (my[p] > 464) my[p] = 464;
            mhop[p]--;
            if (mhop[p] == 0) begin
               if (my[p] <= m_goal[p]) begin
                  msc[p] = (msc[p] >= 99) ? 99 : msc[p] + 1;
                  mx[p] = m_x0[p];
                  my[p] = 448;
               end
               mcool[p] = m_cool[p];
            end
         end else if (mcool[p] > 0) begin
            mcool[p]--;
         end else if (nw != 4'b0) begin
            mdir[p] = nw[3] ? 0 : nw[2] ? 1 : nw[1] ? 2 : 3;
            mhop[p] = 4;
         end
      end
   endtask

   task automatic check_all();
      for (int p = 0; p < 2; p++) begin
         chk($sformatf("A%0d_x", p), 32'(ifa.player_x[10*p +: 10]), mx[p]);
         chk($sformatf("A%0d_y", p), 32'(ifa.player_y[10*p +: 10]), my[p]);
         chk($sformatf("A%0d_score", p), 32'(ifa.player_score[7*p +: 7]), msc[p]);
         chk($sformatf("A%0d_hopping", p), 32'(ifa.player_hopping[p]), 32'(mhop[p] > 0));
      end
      chk("B0_x", 32'(ifb.player_x), mx[2]);
      chk("B0_y", 32'(ifb.player_y), my[2]);
      chk("B0_score", 32'(ifb.player_score), msc[2]);
      chk("B0_hopping", 32'(ifb.player_hopping), 32'(mhop[2] > 0));
   endtask

   task automatic set_in(input logic vs, input logic [31:0] keys);
      ifa.frame_vs = vs; ifb.frame_vs = vs;
      ifa.keycodes = keys; ifb.keycodes = keys;
   endtask

   // One vsync low pulse with the given keys held; the tick must appear
   // on the 4th negedge after vs falls and nowhere else in the window.
   task automatic frame(input logic [31:0] keys);
      @(posedge clk); #1;
      set_in(1'b0, keys);
      for (int n = 0; n < 5; n++) begin
         @(negedge clk);
         chk($sformatf("A_tick_n%0d", n), 32'(ifa.frame_tick), 32'(n == 3));
         chk($sformatf("B_tick_n%0d", n), 32'(ifb.frame_tick), 32'(n == 3));
         if (n == 3) model_tick(keys);
      end
      check_all();
      set_in(1'b1, keys);
      repeat (3) @(posedge clk);
   endtask

   task automatic do_reset();
      @(posedge clk); #1 rst = 1'b1;
      @(posedge clk); #1 rst = 1'b0;
      model_reset();
      @(negedge clk);
      chk("rst_tick", 32'(ifa.frame_tick), 32'd0);
      check_all();
   endtask

   function automatic logic [31:0] rand_keys();
      logic [31:0] k;
      int r;
      k = 32'd0;
      for (int s = 0; s < 4; s++) begin
         r = $urandom_range(0, 9);
         if (r < 4)      k[8*s +: 8] = 8'h00;
         else if (r < 9) k[8*s +: 8] = 8'(km[$urandom_range(0, 3)][$urandom_range(0, 3)]);
         else            k[8*s +: 8] = 8'($urandom_range(0, 255));
      end
      return k;
   endfunction

   logic [31:0] rk;

   initial begin
      set_in(1'b1, 32'd0);
      rst = 1'b1;
      repeat (4) @(posedge clk);
      #1 rst = 1'b0;
      model_reset();
      @(negedge clk);
      chk("init_tick", 32'(ifa.frame_tick), 32'd0);
      check_all();

      frame(32'd0);
      // Held W: exactly one hop.
      repeat (10) frame(32'h0000_001A);
      frame(32'd0);
      // Right for P0 and Up for P1 in the same frame.
      frame(32'h0000_5207);
      repeat (8) frame(32'd0);
      // All four P0 directions new at once: up wins.
      frame(32'h0716_041A);
      repeat (8) frame(32'd0);
      // Toggle W: P0 climbs to the goal; B scores past saturation.
      for (int f = 0; f < 700; f++) frame((f % 2 == 0) ? 32'h0000_001A : 32'd0);
      // Toggle Right: P1 runs into the right wall, presses in cooldown ignored.
      for (int f = 0; f < 240; f++) frame((f % 2 == 0) ? 32'h0000_004F : 32'd0);
      // Random keycodes, sometimes held over several frames.
      rk = 32'd0;
      for (int f = 0; f < 300; f++) begin
         if ($urandom_range(0, 1) == 0) rk = rand_keys();
         frame(rk);
      end
      // Reset mid-hop with W held through it.
      frame(32'd0);
      frame(32'h0000_001A);
      frame(32'h0000_001A);
      do_reset();
      repeat (3) frame(32'h0000_001A);
      frame(32'd0);
      frame(32'h0000_001A);
      repeat (6) frame(32'd0);

      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end

endmodule
